envelope_gen: RTL and testbench



---
 rtl/envelope_gen.sv | 209 ++++++++++++++++++++
 tb/tb_envelope_gen.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/envelope_gen.sv
// ---------------------------------------------------------------------------
// envelope_gen -- ADSR amplitude envelope applied to a tone-generator sample.
//
// A gate-driven ATTACK/DECAY/SUSTAIN/RELEASE state machine steps an unsigned
// envelope level once per prescaler tick. The incoming signed sample is
// scaled by that level and registered toward the mixer.
//
// Ports:
//   clk_in        in   system clock
//   reset         in   synchronous active-high reset
//   gate          in   note on (level-sensitive)
//   attack_rate   in   level increment per tick (low ENV_W bits)
//   decay_rate    in   level decrement per tick in DECAY (low ENV_W bits)
//   sustain_level in   hold level (low ENV_W bits)
//   release_rate  in   level decrement per tick in RELEASE (low ENV_W bits),
//                      or shift amount in [3:0] for the exponential tail
//   sig_in        in   signed tone sample
//   sig_out       out  scaled sample, registered (1-cycle latency)
//   env_level     out  current envelope level
//   busy          out  high while the envelope is not IDLE
//
// Build option:
//   ENV_EXP_RELEASE_EN  defined: RELEASE step = max(1, level >> release_rate[3:0])
//                       undefined: linear RELEASE step = release_rate
// ---------------------------------------------------------------------------

package sysPKG;
  localparam int unsigned CLK_FREQ = 50_000_000;
endpackage

package regPKG;
  typedef logic [31:0] reg_data_t;
endpackage

package synthPKG;
  typedef logic signed [15:0] synth_sig;
endpackage

module envelope_gen #(
  parameter int unsigned CLK_FREQ = sysPKG::CLK_FREQ,
  parameter int unsigned TICK_DIV = CLK_FREQ / 48000,
  parameter int unsigned ENV_W    = 16
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                gate,
  input  regPKG::reg_data_t   attack_rate,
  input  regPKG::reg_data_t   decay_rate,
  input  regPKG::reg_data_t   sustain_level,
  input  regPKG::reg_data_t   release_rate,
  input  synthPKG::synth_sig  sig_in,
  output synthPKG::synth_sig  sig_out,
  output logic [ENV_W-1:0]    env_level,
  output logic                busy
);

  localparam int unsigned SIG_W  = $bits(synthPKG::synth_sig);
  localparam int unsigned REG_W  = $bits(regPKG::reg_data_t);
  localparam int unsigned PROD_W = SIG_W + ENV_W + 1;
  localparam int unsigned DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [ENV_W-1:0] LVL_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_DECAY,
    ST_SUSTAIN,
    ST_RELEASE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ENV_W-1:0]   r_level;
  logic [ENV_W-1:0]   w_level_nxt;
  logic               r_gate_d;
  logic [DIV_W-1:0]   r_div;
  synthPKG::synth_sig r_sig_out;

  logic               w_tick;
  logic               w_rise;
  logic               w_fall;
  logic [ENV_W-1:0]   w_atk;
  logic [ENV_W-1:0]   w_dec;
  logic [ENV_W-1:0]   w_sus;
  logic [ENV_W:0]     w_atk_sum;
  logic [ENV_W:0]     w_dec_floor;
  logic [ENV_W-1:0]   w_rel_step;
  logic               w_rel_zero;

  logic signed [PROD_W-1:0] w_sig_ext;
  logic signed [PROD_W-1:0] w_lvl_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic                     w_unused;

  // Free-running tick prescaler
  assign w_tick = (r_div == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk_in) begin
    if (reset || w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign w_rise = gate & ~r_gate_d;
  assign w_fall = ~gate & r_gate_d;

  assign w_atk = attack_rate[ENV_W-1:0];
  assign w_dec = decay_rate[ENV_W-1:0];
  assign w_sus = sustain_level[ENV_W-1:0];

  // One extra bit so the attack sum cannot wrap and sustain+decay cannot
  // overflow; level - decay <= sustain is tested as level <= sustain + decay.
  assign w_atk_sum   = {1'b0, r_level} + {1'b0, w_atk};
  assign w_dec_floor = {1'b0, w_sus} + {1'b0, w_dec};

`ifdef ENV_EXP_RELEASE_EN
  logic [ENV_W-1:0] w_rel_shr;
  assign w_rel_shr  = r_level >> release_rate[3:0];
  assign w_rel_step = (w_rel_shr == '0) ? ENV_W'(1) : w_rel_shr;
  // Shift of 0 makes the step equal to the level, so it ends in one tick.
  assign w_rel_zero = (r_level <= w_rel_step);
  assign w_unused   = ^{attack_rate[REG_W-1:ENV_W], decay_rate[REG_W-1:ENV_W],
                        sustain_level[REG_W-1:ENV_W], release_rate[REG_W-1:4],
                        w_prod[PROD_W-1:ENV_W+SIG_W], w_prod[ENV_W-1:0]};
`else
  assign w_rel_step = release_rate[ENV_W-1:0];
  assign w_rel_zero = (w_rel_step == '0) || (r_level <= w_rel_step);
  assign w_unused   = ^{attack_rate[REG_W-1:ENV_W], decay_rate[REG_W-1:ENV_W],
                        sustain_level[REG_W-1:ENV_W], release_rate[REG_W-1:ENV_W],
                        w_prod[PROD_W-1:ENV_W+SIG_W], w_prod[ENV_W-1:0]};
`endif

  // Next state / next level. Gate edges pre-empt the tick update so that a
  // coinciding edge and tick only change state, never the level.
  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    if (w_rise) begin
      w_state_nxt = ST_ATTACK;
    end else if (w_fall && (r_state == ST_ATTACK || r_state == ST_DECAY ||
                            r_state == ST_SUSTAIN)) begin
      w_state_nxt = ST_RELEASE;
    end else if (w_tick) begin
      case (r_state)
        ST_IDLE: begin
          w_level_nxt = '0;
        end
        ST_ATTACK: begin
          if (w_atk == '0 || w_atk_sum >= {1'b0, LVL_MAX}) begin
            w_level_nxt = LVL_MAX;
            w_state_nxt = ST_DECAY;
          end else begin
            w_level_nxt = w_atk_sum[ENV_W-1:0];
          end
        end
        ST_DECAY: begin
          if (w_dec == '0 || {1'b0, r_level} <= w_dec_floor) begin
            w_level_nxt = w_sus;
            w_state_nxt = ST_SUSTAIN;
          end else begin
            w_level_nxt = r_level - w_dec;
          end
        end
        ST_SUSTAIN: begin
          w_level_nxt = w_sus;
        end
        ST_RELEASE: begin
          if (w_rel_zero) begin
            w_level_nxt = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_level_nxt = r_level - w_rel_step;
          end
        end
        default: begin
          w_level_nxt = '0;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Signed product of the sample and the zero-extended level; taking bits
  // [ENV_W +: SIG_W] is the arithmetic right shift by ENV_W, truncated.
  assign w_sig_ext = {{(ENV_W + 1){sig_in[SIG_W-1]}}, sig_in};
  assign w_lvl_ext = {{(SIG_W + 1){1'b0}}, r_level};
  assign w_prod    = w_sig_ext * w_lvl_ext;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_level   <= '0;
      r_gate_d  <= 1'b0;
      r_sig_out <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_level   <= w_level_nxt;
      r_gate_d  <= gate;
      r_sig_out <= w_prod[ENV_W +: SIG_W];
    end
  end

  assign sig_out   = r_sig_out;
  assign env_level = r_level;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_envelope_gen.sv
// ---------------------------------------------------------------------------
// tb_envelope_gen -- directed bench for envelope_gen with TICK_DIV=4,
// ENV_W=16, linear release. Ticks land on every 4th clock edge after the
// reset edge; edge_cnt tracks that phase so the bench can step tick by tick.
// ---------------------------------------------------------------------------
module tb_envelope_gen;

  logic               clk_in;
  logic               reset;
  logic               gate;
  regPKG::reg_data_t  attack_rate;
  regPKG::reg_data_t  decay_rate;
  regPKG::reg_data_t  sustain_level;
  regPKG::reg_data_t  release_rate;
  synthPKG::synth_sig sig_in;
  synthPKG::synth_sig sig_out;
  logic [15:0]        env_level;
  logic               busy;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  envelope_gen #(
    .TICK_DIV (4),
    .ENV_W    (16)
  ) dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .gate          (gate),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .sustain_level (sustain_level),
    .release_rate  (release_rate),
    .sig_in        (sig_in),
    .sig_out       (sig_out),
    .env_level     (env_level),
    .busy          (busy)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  always @(posedge clk_in) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // Advance to just after the next tick edge (at most 4 edges).
  task automatic next_tick();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_in);
      #1;
      if (edge_cnt % 4 == 0) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    gate          = 1'b0;
    attack_rate   = 32'h4000;
    decay_rate    = 32'h8000;
    sustain_level = 32'h2000;
    release_rate  = 32'h1000;
    sig_in        = 16'sd1000;
    step(2);
    check("rst_level", env_level, 0);
    check("rst_sig",   sig_out,   0);
    check("rst_busy",  busy,      0);

    // Attack ramp
    reset  = 1'b0;
    gate   = 1'b1;
    sig_in = '0;
    step(1);
    check("atk_busy",   busy,      1);
    check("atk_l0",     env_level, 0);
    next_tick(); check("atk_t1", env_level, 16'h4000);
    next_tick(); check("atk_t2", env_level, 16'h8000);
    next_tick(); check("atk_t3", env_level, 16'hC000);
    next_tick(); check("atk_t4", env_level, 16'hFFFF);

    // Decay into sustain, then sustain tracks the register
    next_tick(); check("dec_t1", env_level, 16'h7FFF);
    next_tick(); check("dec_t2", env_level, 16'h2000);
    next_tick(); check("sus_hold", env_level, 16'h2000);
    sustain_level = 32'h3000;
    next_tick(); check("sus_track", env_level, 16'h3000);

    // Linear release to IDLE
    gate = 1'b0;
    step(1);     check("rel_busy0", busy, 1);
    next_tick(); check("rel_t1", env_level, 16'h2000);
    next_tick(); check("rel_t2", env_level, 16'h1000);
    check("rel_busy1", busy, 1);
    next_tick(); check("rel_t3", env_level, 0);
    check("rel_idle", busy, 0);

    // Retrigger from a RELEASE level
    attack_rate  = 32'h1900;
    release_rate = 32'h0100;
    gate = 1'b1;
    next_tick(); check("rtg_atk", env_level, 16'h1900);
    gate = 1'b0;
    next_tick(); check("rtg_rel", env_level, 16'h1800);
    gate = 1'b1;
    attack_rate = 32'h4000;
    step(1);
    check("rtg_busy",  busy,      1);
    check("rtg_hold",  env_level, 16'h1800);
    next_tick(); check("rtg_t1", env_level, 16'h5800);
    next_tick(); check("rtg_t2", env_level, 16'h9800);
    next_tick(); check("rtg_t3", env_level, 16'hD800);
    next_tick(); check("rtg_t4", env_level, 16'hFFFF);

    // Scaling, including the one-cycle latency
    sig_in = -16'sd16384;
    step(1);     check("scl_full", sig_out, -16384);
    sustain_level = 32'h8000;
    next_tick();
    check("scl_lvl8k", env_level, 16'h8000);
    check("scl_lat",   sig_out,   -16384);
    step(1);     check("scl_half", sig_out, -8192);

    // Zero release rate: straight to 0 on the next tick
    release_rate = 32'h0;
    gate = 1'b0;
    next_tick();
    check("rel0_level", env_level, 0);
    check("rel0_busy",  busy,      0);
    check("rel0_sig",   sig_out,   -8192);
    step(1);     check("scl_zero", sig_out, 0);

    // Reset mid-ATTACK
    gate = 1'b1;
    step(1);     check("ra_busy", busy, 1);
    next_tick(); check("ra_lvl",  env_level, 16'h4000);
    reset = 1'b1;
    step(1);
    check("ra_rst_level", env_level, 0);
    check("ra_rst_sig",   sig_out,   0);
    check("ra_rst_busy",  busy,      0);

    // Gate held through reset yields a rise after release; zero attack rate
    reset = 1'b0;
    attack_rate = 32'h0;
    step(1);     check("post_rst_busy", busy, 1);
    next_tick(); check("atk0_step", env_level, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
